// File: rtl/vga_timing_pkg.sv
// Shared timing defaults and helpers for the VGA sync generator family.
// Defaults describe 640x480@60 with a 25.175 MHz pixel clock.
package vga_timing_pkg;

    localparam int unsigned DEF_H_DISPLAY = 640;
    localparam int unsigned DEF_H_FRONT   = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BACK    = 48;
    localparam int unsigned DEF_V_DISPLAY = 480;
    localparam int unsigned DEF_V_FRONT   = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BACK    = 33;
    localparam int unsigned DEF_CW        = 10;
    localparam int unsigned DEF_FRAME_W   = 12;

    typedef logic [DEF_CW-1:0] pos_t;

    function automatic int unsigned span_total(input int unsigned disp,
                                               input int unsigned front,
                                               input int unsigned sync,
                                               input int unsigned back);
        return disp + front + sync + back;
    endfunction

    function automatic int unsigned sync_start(input int unsigned disp,
                                               input int unsigned front);
        return disp + front;
    endfunction

    function automatic int unsigned sync_end(input int unsigned disp,
                                             input int unsigned front,
                                             input int unsigned sync);
        return disp + front + sync;
    endfunction

    // Returns the pin level for a position: active level inside [start, stop).
    function automatic logic sync_level(input int unsigned pos,
                                        input int unsigned start,
                                        input int unsigned stop,
                                        input bit          activeHigh);
        return ((pos >= start) && (pos < stop)) == activeHigh;
    endfunction

endpackage

// File: rtl/vga_wrap_counter.sv
// Enabled up-counter that wraps to zero after reaching last_i.
// next_o is the value after the next enabled cycle, independent of en_i.
module vga_wrap_counter #(
    parameter int unsigned W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic [W-1:0] last_i,
    output logic [W-1:0] count_o,
    output logic [W-1:0] next_o,
    output logic         wrap_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic         atLast;

    assign atLast  = (count_q == last_i);
    assign next_o  = atLast ? '0 : count_q + W'(1);
    assign wrap_o  = en_i && atLast;
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = next_o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: beam position, registered syncs, strobes, frame counter.
// Define VGA_TIMING_PREFETCH_EN to expose next_hpos/next_vpos/next_display_on.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_DISPLAY        = DEF_H_DISPLAY,
    parameter int unsigned H_FRONT          = DEF_H_FRONT,
    parameter int unsigned H_SYNC           = DEF_H_SYNC,
    parameter int unsigned H_BACK           = DEF_H_BACK,
    parameter int unsigned V_DISPLAY        = DEF_V_DISPLAY,
    parameter int unsigned V_FRONT          = DEF_V_FRONT,
    parameter int unsigned V_SYNC           = DEF_V_SYNC,
    parameter int unsigned V_BACK           = DEF_V_BACK,
    parameter bit          SYNC_ACTIVE_HIGH = 1'b0,
    parameter int unsigned CW               = DEF_CW,
    parameter int unsigned FRAME_W          = DEF_FRAME_W,
    parameter int unsigned FRAME_INIT       = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pix_en,
    output logic [CW-1:0]      hpos,
    output logic [CW-1:0]      vpos,
    output logic               hsync,
    output logic               vsync,
    output logic               display_on,
    output logic               line_start,
    output logic               frame_start,
`ifdef VGA_TIMING_PREFETCH_EN
    output logic [CW-1:0]      next_hpos,
    output logic [CW-1:0]      next_vpos,
    output logic               next_display_on,
`endif
    output logic [FRAME_W-1:0] frame_count
);

    localparam int unsigned H_TOTAL      = span_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL      = span_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
    localparam int unsigned H_SYNC_START = sync_start(H_DISPLAY, H_FRONT);
    localparam int unsigned H_SYNC_END   = sync_end(H_DISPLAY, H_FRONT, H_SYNC);
    localparam int unsigned V_SYNC_START = sync_start(V_DISPLAY, V_FRONT);
    localparam int unsigned V_SYNC_END   = sync_end(V_DISPLAY, V_FRONT, V_SYNC);
    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);

    if (CW == 0 || FRAME_W == 0 || H_DISPLAY == 0 || H_SYNC == 0 ||
        V_DISPLAY == 0 || V_SYNC == 0) begin : gZeroWidth
        $error("vga_timing_gen: width parameters must be non-zero");
    end
    if (64'(H_TOTAL) > (64'd1 << CW)) begin : gHTooWide
        $error("vga_timing_gen: H_TOTAL does not fit in CW bits");
    end
    if (64'(V_TOTAL) > (64'd1 << CW)) begin : gVTooWide
        $error("vga_timing_gen: V_TOTAL does not fit in CW bits");
    end

    logic [CW-1:0]      hNext;
    logic [CW-1:0]      vNext;
    logic [CW-1:0]      vNextPix;
    logic               hWrap;
    logic               vWrap;
    logic               hsync_q;
    logic               hsync_d;
    logic               vsync_q;
    logic               vsync_d;
    logic [FRAME_W-1:0] frameCount_q;
    logic [FRAME_W-1:0] frameCount_d;

    vga_wrap_counter #(.W(CW)) uHCount (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (pix_en),
        .last_i  (H_LAST),
        .count_o (hpos),
        .next_o  (hNext),
        .wrap_o  (hWrap)
    );

    vga_wrap_counter #(.W(CW)) uVCount (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (hWrap),
        .last_i  (V_LAST),
        .count_o (vpos),
        .next_o  (vNext),
        .wrap_o  (vWrap)
    );

    // Line the beam holds after this cycle when pix_en is high.
    assign vNextPix = hWrap ? vNext : vpos;

    // Syncs are decoded from the upcoming position so they land with hpos/vpos.
    always_comb begin
        hsync_d      = hsync_q;
        vsync_d      = vsync_q;
        frameCount_d = frameCount_q;
        if (pix_en) begin
            hsync_d = sync_level(32'(hNext), H_SYNC_START, H_SYNC_END, SYNC_ACTIVE_HIGH);
            vsync_d = sync_level(32'(vNextPix), V_SYNC_START, V_SYNC_END, SYNC_ACTIVE_HIGH);
        end
        if (vWrap) begin
            frameCount_d = frameCount_q + FRAME_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q      <= ~SYNC_ACTIVE_HIGH;
            vsync_q      <= ~SYNC_ACTIVE_HIGH;
            frameCount_q <= FRAME_W'(FRAME_INIT);
        end else begin
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            frameCount_q <= frameCount_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_count = frameCount_q;
    assign display_on  = (32'(hpos) < H_DISPLAY) && (32'(vpos) < V_DISPLAY);
    assign line_start  = pix_en && (hpos == '0);
    assign frame_start = pix_en && (hpos == '0) && (vpos == '0);

`ifdef VGA_TIMING_PREFETCH_EN
    logic hAtLast;

    assign hAtLast         = (hpos == H_LAST);
    assign next_hpos       = hNext;
    assign next_vpos       = hAtLast ? vNext : vpos;
    assign next_display_on = (32'(next_hpos) < H_DISPLAY) && (32'(next_vpos) < V_DISPLAY);
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed testbench for vga_timing_gen: default, short-frame and tiny-timing instances.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int testsRun    = 0;
    int testsFailed = 0;

    // Default 640x480 instance
    logic       dRst_n, dPix;
    logic [9:0] dHpos, dVpos;
    logic       dHsync, dVsync, dDisp, dLine, dFrame;
    logic [11:0] dCount;
    // 800-pixel lines, 15-line frames (V 8/2/2/3), FRAME_INIT=5
    logic       mRst_n, mPix;
    logic [9:0] mHpos, mVpos;
    logic       mHsync, mVsync, mDisp, mLine, mFrame;
    logic [11:0] mCount;
    // Tiny H=8/1/2/1, V=4/1/1/1, FRAME_W=3, active-high syncs
    logic       tRst_n, tPix;
    logic [9:0] tHpos, tVpos;
    logic       tHsync, tVsync, tDisp, tLine, tFrame;
    logic [2:0] tCount;
`ifdef VGA_TIMING_PREFETCH_EN
    logic [9:0] dNextH, dNextV, mNextH, mNextV, tNextH, tNextV;
    logic       dNextDisp, mNextDisp, tNextDisp;
`endif

    vga_timing_gen uDutDef (
        .clk(clk), .rst_n(dRst_n), .pix_en(dPix), .hpos(dHpos), .vpos(dVpos),
        .hsync(dHsync), .vsync(dVsync), .display_on(dDisp), .line_start(dLine),
        .frame_start(dFrame),
`ifdef VGA_TIMING_PREFETCH_EN
        .next_hpos(dNextH), .next_vpos(dNextV), .next_display_on(dNextDisp),
`endif
        .frame_count(dCount)
    );

    vga_timing_gen #(
        .V_DISPLAY(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .FRAME_INIT(5)
    ) uDutMid (
        .clk(clk), .rst_n(mRst_n), .pix_en(mPix), .hpos(mHpos), .vpos(mVpos),
        .hsync(mHsync), .vsync(mVsync), .display_on(mDisp), .line_start(mLine),
        .frame_start(mFrame),
`ifdef VGA_TIMING_PREFETCH_EN
        .next_hpos(mNextH), .next_vpos(mNextV), .next_display_on(mNextDisp),
`endif
        .frame_count(mCount)
    );

    vga_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .SYNC_ACTIVE_HIGH(1'b1), .FRAME_W(3)
    ) uDutTiny (
        .clk(clk), .rst_n(tRst_n), .pix_en(tPix), .hpos(tHpos), .vpos(tVpos),
        .hsync(tHsync), .vsync(tVsync), .display_on(tDisp), .line_start(tLine),
        .frame_start(tFrame),
`ifdef VGA_TIMING_PREFETCH_EN
        .next_hpos(tNextH), .next_vpos(tNextV), .next_display_on(tNextDisp),
`endif
        .frame_count(tCount)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        dPix = 1'b1;
        dRst_n = 1'b0;
        tick(2);
        testsRun++; if (dHpos !== 10'd0) begin testsFailed++; $display("[TB] FAIL reset_hpos got %0d want 0", dHpos); end
        testsRun++; if (dVpos !== 10'd0) begin testsFailed++; $display("[TB] FAIL reset_vpos got %0d want 0", dVpos); end
        testsRun++; if (dHsync !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_hsync got %b want 1", dHsync); end
        testsRun++; if (dVsync !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_vsync got %b want 1", dVsync); end
        testsRun++; if (dDisp !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_display_on got %b want 1", dDisp); end
        testsRun++; if (dFrame !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_frame_start got %b want 1", dFrame); end
        testsRun++; if (dLine !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_line_start got %b want 1", dLine); end
        testsRun++; if (dCount !== 12'd0) begin testsFailed++; $display("[TB] FAIL reset_frame_count got %0d want 0", dCount); end
        dPix = 1'b0;
        #1;
        testsRun++; if (dFrame !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_frame_start_nopix got %b want 0", dFrame); end
        testsRun++; if (dLine !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_line_start_nopix got %b want 0", dLine); end
        dPix = 1'b1;
        dRst_n = 1'b1;
        #1;
    endtask

    task automatic test_line0();
        int   lowCount = 0;
        logic expHs;
        for (int i = 0; i < 800; i++) begin
            expHs = !((i >= 656) && (i < 752));
            if (dHsync === 1'b0) lowCount++;
            testsRun++; if (dHpos !== 10'(i)) begin testsFailed++; $display("[TB] FAIL line0_hpos got %0d want %0d", dHpos, i); end
            testsRun++; if (dVpos !== 10'd0) begin testsFailed++; $display("[TB] FAIL line0_vpos at h=%0d got %0d want 0", i, dVpos); end
            testsRun++; if (dHsync !== expHs) begin testsFailed++; $display("[TB] FAIL line0_hsync at h=%0d got %b want %b", i, dHsync, expHs); end
            testsRun++; if (dVsync !== 1'b1) begin testsFailed++; $display("[TB] FAIL line0_vsync at h=%0d got %b want 1", i, dVsync); end
            testsRun++; if (dDisp !== (i < 640)) begin testsFailed++; $display("[TB] FAIL line0_display_on at h=%0d got %b want %b", i, dDisp, (i < 640)); end
            testsRun++; if (dLine !== (i == 0)) begin testsFailed++; $display("[TB] FAIL line0_line_start at h=%0d got %b want %b", i, dLine, (i == 0)); end
`ifdef VGA_TIMING_PREFETCH_EN
            testsRun++; if (dNextH !== 10'((i + 1) % 800)) begin testsFailed++; $display("[TB] FAIL line0_next_hpos at h=%0d got %0d want %0d", i, dNextH, (i + 1) % 800); end
            testsRun++; if (dNextV !== 10'((i == 799) ? 1 : 0)) begin testsFailed++; $display("[TB] FAIL line0_next_vpos at h=%0d got %0d", i, dNextV); end
            testsRun++; if (dNextDisp !== (((i + 1) % 800) < 640)) begin testsFailed++; $display("[TB] FAIL line0_next_display_on at h=%0d got %b", i, dNextDisp); end
`endif
            tick(1);
        end
        testsRun++; if (lowCount != 96) begin testsFailed++; $display("[TB] FAIL line0_hsync_width got %0d want 96", lowCount); end
        testsRun++; if (dHpos !== 10'd0) begin testsFailed++; $display("[TB] FAIL line1_hpos got %0d want 0", dHpos); end
        testsRun++; if (dVpos !== 10'd1) begin testsFailed++; $display("[TB] FAIL line1_vpos got %0d want 1", dVpos); end
        testsRun++; if (dLine !== 1'b1) begin testsFailed++; $display("[TB] FAIL line1_line_start got %b want 1", dLine); end
        testsRun++; if (dFrame !== 1'b0) begin testsFailed++; $display("[TB] FAIL line1_frame_start got %b want 0", dFrame); end
    endtask

    task automatic test_pix_toggle();
        int   p = 0, h, v, lines = 0, frames = 0;
        logic pixNow, expHs, expVs, expDisp, expLine, expFrame;
        tRst_n = 1'b1;
        for (int k = 0; k < 168; k++) begin
            pixNow = (k % 2 == 0);
            tPix = pixNow;
            #1;
            h = p % 12;
            v = (p / 12) % 7;
            expHs    = (h >= 9) && (h < 11);
            expVs    = (v == 5);
            expDisp  = (h < 8) && (v < 4);
            expLine  = pixNow && (h == 0);
            expFrame = pixNow && (h == 0) && (v == 0);
            if (tLine === 1'b1) lines++;
            if (tFrame === 1'b1) frames++;
            testsRun++; if (tHpos !== 10'(h)) begin testsFailed++; $display("[TB] FAIL toggle_hpos k=%0d got %0d want %0d", k, tHpos, h); end
            testsRun++; if (tVpos !== 10'(v)) begin testsFailed++; $display("[TB] FAIL toggle_vpos k=%0d got %0d want %0d", k, tVpos, v); end
            testsRun++; if (tHsync !== expHs) begin testsFailed++; $display("[TB] FAIL toggle_hsync k=%0d got %b want %b", k, tHsync, expHs); end
            testsRun++; if (tVsync !== expVs) begin testsFailed++; $display("[TB] FAIL toggle_vsync k=%0d got %b want %b", k, tVsync, expVs); end
            testsRun++; if (tDisp !== expDisp) begin testsFailed++; $display("[TB] FAIL toggle_display_on k=%0d got %b want %b", k, tDisp, expDisp); end
            testsRun++; if (tLine !== expLine) begin testsFailed++; $display("[TB] FAIL toggle_line_start k=%0d got %b want %b", k, tLine, expLine); end
            testsRun++; if (tFrame !== expFrame) begin testsFailed++; $display("[TB] FAIL toggle_frame_start k=%0d got %b want %b", k, tFrame, expFrame); end
            @(posedge clk);
            #1;
            if (pixNow) p++;
        end
        testsRun++; if (lines != 7) begin testsFailed++; $display("[TB] FAIL toggle_line_count got %0d want 7", lines); end
        testsRun++; if (frames != 1) begin testsFailed++; $display("[TB] FAIL toggle_frame_starts got %0d want 1", frames); end
        testsRun++; if (tCount !== 3'd1) begin testsFailed++; $display("[TB] FAIL toggle_frame_count got %0d want 1", tCount); end
        testsRun++; if ((tHpos !== 10'd0) || (tVpos !== 10'd0)) begin testsFailed++; $display("[TB] FAIL toggle_end_pos got (%0d,%0d) want (0,0)", tHpos, tVpos); end
    endtask

    task automatic test_frame_wrap();
        tPix = 1'b1;
        for (int f = 0; f < 7; f++) begin
            tick(83);
            testsRun++; if (tCount !== 3'((1 + f) % 8)) begin testsFailed++; $display("[TB] FAIL wrap_count_before f=%0d got %0d want %0d", f, tCount, (1 + f) % 8); end
            testsRun++; if ((tHpos !== 10'd11) || (tVpos !== 10'd6)) begin testsFailed++; $display("[TB] FAIL wrap_pos_before f=%0d got (%0d,%0d) want (11,6)", f, tHpos, tVpos); end
            tick(1);
            testsRun++; if (tCount !== 3'((2 + f) % 8)) begin testsFailed++; $display("[TB] FAIL wrap_count_after f=%0d got %0d want %0d", f, tCount, (2 + f) % 8); end
            testsRun++; if (tFrame !== 1'b1) begin testsFailed++; $display("[TB] FAIL wrap_frame_start f=%0d got %b want 1", f, tFrame); end
        end
    endtask

    task automatic test_vsync_frame();
        int   h, v, lines = 0, frames = 0;
        logic expVs, expHs, expDisp;
        mPix = 1'b1;
        mRst_n = 1'b1;
        for (int i = 0; i < 12000; i++) begin
            h = i % 800;
            v = i / 800;
            expVs   = !((v >= 10) && (v < 12));
            expHs   = !((h >= 656) && (h < 752));
            expDisp = (h < 640) && (v < 8);
            if (mLine === 1'b1) lines++;
            if (mFrame === 1'b1) frames++;
            testsRun++; if (mHpos !== 10'(h)) begin testsFailed++; $display("[TB] FAIL mid_hpos i=%0d got %0d want %0d", i, mHpos, h); end
            testsRun++; if (mVpos !== 10'(v)) begin testsFailed++; $display("[TB] FAIL mid_vpos i=%0d got %0d want %0d", i, mVpos, v); end
            testsRun++; if (mVsync !== expVs) begin testsFailed++; $display("[TB] FAIL mid_vsync (%0d,%0d) got %b want %b", h, v, mVsync, expVs); end
            testsRun++; if (mHsync !== expHs) begin testsFailed++; $display("[TB] FAIL mid_hsync (%0d,%0d) got %b want %b", h, v, mHsync, expHs); end
            testsRun++; if (mDisp !== expDisp) begin testsFailed++; $display("[TB] FAIL mid_display_on (%0d,%0d) got %b want %b", h, v, mDisp, expDisp); end
            testsRun++; if (mCount !== 12'd5) begin testsFailed++; $display("[TB] FAIL mid_count_stable i=%0d got %0d want 5", i, mCount); end
            tick(1);
        end
        testsRun++; if (lines != 15) begin testsFailed++; $display("[TB] FAIL mid_line_starts got %0d want 15", lines); end
        testsRun++; if (frames != 1) begin testsFailed++; $display("[TB] FAIL mid_frame_starts got %0d want 1", frames); end
        testsRun++; if (mCount !== 12'd6) begin testsFailed++; $display("[TB] FAIL mid_frame_count got %0d want 6", mCount); end
        testsRun++; if ((mHpos !== 10'd0) || (mVpos !== 10'd0)) begin testsFailed++; $display("[TB] FAIL mid_end_pos got (%0d,%0d) want (0,0)", mHpos, mVpos); end
    endtask

    task automatic test_reset_mid();
        tick(8500);
        testsRun++; if ((mHpos !== 10'd500) || (mVpos !== 10'd10)) begin testsFailed++; $display("[TB] FAIL rstmid_pre_pos got (%0d,%0d) want (500,10)", mHpos, mVpos); end
        testsRun++; if (mVsync !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstmid_pre_vsync got %b want 0", mVsync); end
        mRst_n = 1'b0;
        #1;
        testsRun++; if ((mHpos !== 10'd0) || (mVpos !== 10'd0)) begin testsFailed++; $display("[TB] FAIL rstmid_pos got (%0d,%0d) want (0,0)", mHpos, mVpos); end
        testsRun++; if ((mHsync !== 1'b1) || (mVsync !== 1'b1)) begin testsFailed++; $display("[TB] FAIL rstmid_syncs got h=%b v=%b want 1/1", mHsync, mVsync); end
        testsRun++; if (mCount !== 12'd5) begin testsFailed++; $display("[TB] FAIL rstmid_count got %0d want 5", mCount); end
        testsRun++; if (mFrame !== 1'b1) begin testsFailed++; $display("[TB] FAIL rstmid_frame_start got %b want 1", mFrame); end
        tick(2);
        mRst_n = 1'b1;
        tick(1);
        testsRun++; if ((mHpos !== 10'd1) || (mVpos !== 10'd0)) begin testsFailed++; $display("[TB] FAIL rstmid_resume got (%0d,%0d) want (1,0)", mHpos, mVpos); end
        tick(799);
        testsRun++; if ((mHpos !== 10'd0) || (mVpos !== 10'd1)) begin testsFailed++; $display("[TB] FAIL rstmid_line1 got (%0d,%0d) want (0,1)", mHpos, mVpos); end
        testsRun++; if (mCount !== 12'd5) begin testsFailed++; $display("[TB] FAIL rstmid_count_after got %0d want 5", mCount); end
    endtask

    initial begin
        dRst_n = 1'b0; mRst_n = 1'b0; tRst_n = 1'b0;
        dPix   = 1'b1; mPix   = 1'b1; tPix   = 1'b1;
        tick(2);
        test_reset();
        test_line0();
        test_pix_toggle();
        test_frame_wrap();
        test_vsync_frame();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
